// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder : packs RV32I instruction fields into 32-bit words and writes
//                 them to IMEM at an auto-incrementing word address.
// Revision      : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module instr_encoder #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        func3,
  input  logic [6:0]        func7,
  input  logic [31:0]       imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_PEND  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;
  localparam logic [ADDR_W-1:0] BASE_WADDR = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   COUNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;

  logic [31:0]       enc_word;
  logic              fmt_legal;
  logic              at_last;
  logic              accept_in;

  always_comb begin
    enc_word = 32'h0;
    case (fmt)
      3'd0: enc_word = {func7, rs2, rs1, func3, rd, opcode};
      3'd1: enc_word = {imm[11:0], rs1, func3, rd, opcode};
      3'd2: enc_word = {imm[11:5], rs2, rs1, func3, imm[4:0], opcode};
      3'd3: enc_word = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode};
      3'd4: enc_word = {imm[31:12], rd, opcode};
      3'd5: enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: enc_word = 32'h0;
    endcase
  end

  assign fmt_legal = (fmt <= 3'd5);
  assign at_last   = (addr_q == LAST_ADDR);
  // A new bundle may ride on the same edge that retires the buffered word,
  // except when that word fills the last address.
  assign in_ready  = (state_q == ST_EMPTY) ||
                     ((state_q == ST_PEND) && mem_ready && !at_last);
  assign accept_in = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    if (start) begin
      state_d = ST_EMPTY;
      addr_d  = BASE_WADDR;
      count_d = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept_in) begin
            if (fmt_legal) begin
              wdata_d = enc_word;
              state_d = ST_PEND;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ST_PEND: begin
          if (mem_ready) begin
            count_d = count_q + COUNT_ONE;
            if (at_last) begin
              state_d = ST_FULL;
            end else begin
              addr_d = addr_q + ADDR_ONE;
              if (accept_in && fmt_legal) begin
                wdata_d = enc_word;
                state_d = ST_PEND;
              end else begin
                state_d = ST_EMPTY;
                if (accept_in) err_d = 1'b1;
              end
            end
          end
        end
        ST_FULL: state_d = ST_FULL;
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_EMPTY;
      addr_q  <= BASE_WADDR;
      count_q <= '0;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign mem_we    = (state_q == ST_PEND);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign count     = count_q;
  assign full      = (state_q == ST_FULL);
  assign err       = err_q;

endmodule

`default_nettype wire

// File: doc/instr_encoder.md
# instr_encoder

Sequential RISC-V instruction encoder: the inverse of the pipeline's IF/ID field decoder. It accepts instruction fields plus a format code over a valid/ready handshake, packs them into a 32-bit RV32I word, and writes the word into instruction memory at an auto-incrementing address. It is used by the debug/loader path to assemble programs into IMEM before or while the CPU is halted. One output buffer stage decouples field input from a memory port that may stall.

## Interface
- ADDR_W, 8: IMEM word-address width; capacity 2^ADDR_W words.
- BASE_ADDR, 0: word address loaded on reset and on `start`.
- clk  in  1  system clock, all state on rising edge
- rstn  in  1  synchronous, active-low reset
- start  in  1  pulse: reload address to BASE_ADDR, clear `full`, `err`, `count`
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept bundle this cycle
- fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal
- opcode  in  7  instr[6:0]
- rd  in  5  destination register
- rs1  in  5  source register 1
- rs2  in  5  source register 2
- func3  in  3  instr[14:12]
- func7  in  7  instr[31:25], R only
- imm  in  32  immediate, byte-offset form (B/J bit 0 ignored)
- mem_we  out  1  write request, held until accepted
- mem_addr  out  ADDR_W  word address of write
- mem_wdata  out  32  encoded instruction
- mem_ready  in  1  memory accepts write when mem_we & mem_ready
- count  out  ADDR_W+1  words written since reset/start
- full  out  1  last address written; further input refused
- err  out  1  sticky: illegal fmt received

## Operation
- Packing (bit concatenation, MSB first):
  - R: func7, rs2, rs1, func3, rd, opcode
  - I: imm[11:0], rs1, func3, rd, opcode
  - S: imm[11:5], rs2, rs1, func3, imm[4:0], opcode
  - B: imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode
  - U: imm[31:12], rd, opcode
  - J: imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode
- Fields unused by the format are ignored; no sign checking of imm.
- States: EMPTY (no word buffered), PEND (word buffered, mem_we=1), FULL (capacity reached).
- EMPTY: handshake with legal fmt -> latch word, mem_addr=current addr, go PEND. Illegal fmt: handshake completes, err<=1, nothing buffered, stays EMPTY.
- PEND: on mem_we & mem_ready -> count+1, addr+1. If that write was to address 2^ADDR_W-1 -> FULL. Else if a new legal bundle is handshaked the same cycle -> stay PEND with new word (back-to-back). Else -> EMPTY.
- in_ready = (state==EMPTY) | (state==PEND & mem_ready & addr != 2^ADDR_W-1).
- FULL: in_ready=0, mem_we=0; exits only via start or reset.
- start has priority over every event; a buffered, unaccepted word is discarded; next state EMPTY.
- Address wraps never; count saturates implicitly at 2^ADDR_W - BASE_ADDR.

## Timing
- Reset (rstn=0 at edge): state EMPTY, addr=BASE_ADDR, mem_we=0, mem_wdata=0, count=0, full=0, err=0; in_ready=1 in the following cycle.
- Latency: bundle handshaked in cycle N -> mem_we=1 with its word from cycle N+1.
- Throughput: 1 word/cycle while mem_ready stays 1.
- mem_addr/mem_wdata stable while mem_we=1 and mem_ready=0.
- count/full update in the cycle after the accepting edge.
- Reset mid-write: pending word dropped, no partial state survives.

## Test plan
- Reset, then I fmt opcode 0x13 rd=1 rs1=0 func3=0 imm=5 -> mem_we next cycle, addr 0, wdata 0x00500093, count=1 after accept.
- Back-to-back R add x3,x1,x2 (0x33) then S sw x2,8(x1) (0x23, func3=2), mem_ready=1 -> 0x002081B3 @0, 0x0020A423 @1 on consecutive cycles.
- B beq x0,x0,imm=0xFFFFFFFC (0x63) with mem_ready low 3 cycles -> 0xFE000EE3 held stable, in_ready=0 while stalled, written once.
- J jal x1,imm=8 (0x6F) -> 0x008000EF; fmt=7 bundle -> err=1, no write, count unchanged.
- ADDR_W=2: write 4 words -> full=1, in_ready=0 after 4th accept; 5th bundle not taken; start -> full=0, count=0, addr=0.
- Assert rstn=0 while PEND with mem_ready=0 -> next cycle mem_we=0, count=0, err=0.
